// File: rtl/fp_max_pool_pkg.sv
// rtl/fp_max_pool_pkg.sv - shared FP32 field positions and pooling FSM encoding
package fp_max_pool_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_POOL = 3'd2;
  localparam logic [2:0] ST_EMIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    POOL = ST_POOL,
    EMIT = ST_EMIT,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/fp32_max_cmp.sv
// rtl/fp32_max_cmp.sv - combinational FP32 max by sign-magnitude ordering
// NaN/Inf are ordered by bit pattern like any other value; ties return a.
module fp32_max_cmp
  import fp_max_pool_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        sign_a;
  logic        sign_b;
  logic [30:0] mag_a;
  logic [30:0] mag_b;
  logic        pick_a;

  always_comb begin
    sign_a = a[SIGN_BIT];
    sign_b = b[SIGN_BIT];
    mag_a  = {a[EXP_MSB:EXP_LSB], a[MANT_MSB:0]};
    mag_b  = {b[EXP_MSB:EXP_LSB], b[MANT_MSB:0]};
    pick_a = 1'b1;
    if (sign_a != sign_b) begin
      pick_a = !sign_a;
    end else if (!sign_a) begin
      pick_a = (mag_a >= mag_b);
    end else begin
      // among negatives the smaller magnitude is the larger value
      pick_a = (mag_a <= mag_b);
    end
    y = pick_a ? a : b;
  end

endmodule

// File: rtl/fp_max_pool.sv
// rtl/fp_max_pool.sv - buffers a serialized OxO FP32 map, then emits KxK/stride-S max pools
module fp_max_pool
  import fp_max_pool_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] DIN,
  input  logic             DIN_VALID,
  input  logic [5:0]       O1,
  input  logic [5:0]       K1,
  input  logic [5:0]       S1,
  output logic [Width-1:0] POOL_OUT,
  output logic             POOL_VALID,
  output logic             DONE_ALL
);

  localparam int AW = $clog2(Depth);

  state_t state;
  state_t state_n;

  logic [Width-1:0] mem [Depth];

  logic [5:0]       o_r, k_r, s_r;
  logic [11:0]      n_tot;
  logic [11:0]      wr_cnt;
  logic [5:0]       row0, col0, i_r, j_r;
  logic [Width-1:0] acc;
  logic [Width-1:0] pool_out;
  logic             pool_valid;

  logic [11:0]      ntot_in;
  logic             bad_cfg;
  logic             wr_en;
  logic [11:0]      addr;
  logic [Width-1:0] elem;
  logic [Width-1:0] max_y;
  logic [Width-1:0] acc_n;
  logic             first_el;
  logic             j_wrap;
  logic             last_el;
  logic [11:0]      col_adv;
  logic [5:0]       col0_n;
  logic [11:0]      row0_n;
  logic             unused_bits;

  always_comb begin
    ntot_in  = {6'd0, O1} * {6'd0, O1};
    bad_cfg  = (K1 == 6'd0) || (S1 == 6'd0) || (K1 > O1) || (ntot_in > 12'(Depth));
    wr_en    = (state == LOAD) && DIN_VALID && (wr_cnt < n_tot);
    addr     = ({6'd0, row0} + {6'd0, i_r}) * {6'd0, o_r} + {6'd0, col0} + {6'd0, j_r};
    elem     = mem[addr[AW-1:0]];
    first_el = (i_r == 6'd0) && (j_r == 6'd0);
    acc_n    = first_el ? elem : max_y;
    j_wrap   = (j_r == 6'(k_r - 6'd1));
    last_el  = j_wrap && (i_r == 6'(k_r - 6'd1));
    col_adv  = {6'd0, col0} + {6'd0, s_r} + {6'd0, k_r};
    if (col_adv <= {6'd0, o_r}) begin
      col0_n = 6'(col0 + s_r);
      row0_n = {6'd0, row0};
    end else begin
      col0_n = 6'd0;
      row0_n = {6'd0, row0} + {6'd0, s_r};
    end
    unused_bits = ^{addr[11:AW], wr_cnt[11:AW]};
  end

  fp32_max_cmp u_cmp (
    .a (acc),
    .b (elem),
    .y (max_y)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bad_cfg ? DONE : LOAD;
      // leave on the write of the last word so pooling starts immediately after it
      LOAD: if ((wr_cnt == n_tot) || (wr_en && (wr_cnt + 12'd1 == n_tot))) state_n = POOL;
      POOL: if (last_el) state_n = EMIT;
      EMIT: state_n = ((row0_n + {6'd0, k_r}) > {6'd0, o_r}) ? DONE : POOL;
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_cnt[AW-1:0]] <= DIN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_r        <= '0;
      k_r        <= '0;
      s_r        <= '0;
      n_tot      <= '0;
      wr_cnt     <= '0;
      row0       <= '0;
      col0       <= '0;
      i_r        <= '0;
      j_r        <= '0;
      acc        <= '0;
      pool_out   <= '0;
      pool_valid <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_r    <= O1;
          k_r    <= K1;
          s_r    <= S1;
          n_tot  <= ntot_in;
          wr_cnt <= '0;
          row0   <= '0;
          col0   <= '0;
          i_r    <= '0;
          j_r    <= '0;
        end
        LOAD: if (wr_en) wr_cnt <= wr_cnt + 12'd1;
        POOL: begin
          acc <= acc_n;
          if (j_wrap) begin
            j_r <= '0;
            i_r <= last_el ? 6'd0 : 6'(i_r + 6'd1);
          end else begin
            j_r <= 6'(j_r + 6'd1);
          end
          // result is registered with the final element so the strobe lands in EMIT
          if (last_el) begin
            pool_out   <= acc_n;
            pool_valid <= 1'b1;
          end
        end
        EMIT: begin
          col0 <= col0_n;
          row0 <= row0_n[5:0];
        end
        default: ;
      endcase
    end
  end

  assign POOL_OUT   = pool_out;
  assign POOL_VALID = pool_valid;
  assign DONE_ALL   = (state == DONE);

endmodule

// File: tb/tb_fp_max_pool.sv
// tb/tb_fp_max_pool.sv - scoreboard bench for fp_max_pool with directed pooling vectors
module tb_fp_max_pool;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] DIN = '0;
  logic        DIN_VALID = 1'b0;
  logic [5:0]  O1 = '0;
  logic [5:0]  K1 = '0;
  logic [5:0]  S1 = '0;
  logic [31:0] POOL_OUT;
  logic        POOL_VALID;
  logic        DONE_ALL;

  fp_max_pool #(.Width(32), .Depth(64)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIN        (DIN),
    .DIN_VALID  (DIN_VALID),
    .O1         (O1),
    .K1         (K1),
    .S1         (S1),
    .POOL_OUT   (POOL_OUT),
    .POOL_VALID (POOL_VALID),
    .DONE_ALL   (DONE_ALL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] vin[64];
  int          n_in;
  logic [31:0] fp_int[17];
  logic [31:0] last_exp;
  int          wr_cyc;
  int          prev_cyc;
  int          kk;
  bit          first_strobe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (!RST && POOL_VALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", POOL_OUT, 32'hxxxxxxxx);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("pool_out", POOL_OUT, e);
          check(first_strobe ? "first_latency" : "strobe_spacing",
                first_strobe ? 32'(cyc - wr_cyc) : 32'(cyc - prev_cyc), 32'(kk + 1));
          first_strobe = 1'b0;
          prev_cyc = cyc;
        end
      end
    end
  endtask

  task automatic start(input int o, input int k, input int s);
    @(negedge CLK);
    RST = 1'b1;
    DIN_VALID = 1'b0;
    @(negedge CLK);
    O1 = 6'(o);
    K1 = 6'(k);
    S1 = 6'(s);
    kk = k * k;
    first_strobe = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic stream(input bit gap, input int extra);
    @(negedge CLK);
    for (int n = 0; n < n_in + extra; n++) begin
      DIN = (n < n_in) ? vin[n] : 32'h7F000000;
      DIN_VALID = 1'b1;
      if (n == n_in - 1) wr_cyc = cyc;
      @(negedge CLK);
      if (gap) begin
        DIN_VALID = 1'b0;
        @(negedge CLK);
      end
    end
    DIN_VALID = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!DONE_ALL && t < 400) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_done_all"}, 32'(DONE_ALL), 32'd1);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_held_out"}, POOL_OUT, last_exp);
  endtask

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic basic_case(input string name, input bit gap, input int extra);
    start(4, 2, 2);
    n_in = 16;
    for (int n = 0; n < 16; n++) vin[n] = fp_int[n + 1];
    push(32'h40C00000);
    push(32'h41000000);
    push(32'h41600000);
    push(32'h41800000);
    stream(gap, extra);
    wait_done(name);
  endtask

  task automatic degen(input string name, input int o, input int k, input int s);
    int t;
    start(o, k, s);
    t = 0;
    while (!DONE_ALL && t < 5) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_done_within_2"}, 32'(DONE_ALL && t <= 2), 32'd1);
    check({name, "_pool_out_zero"}, POOL_OUT, 32'h0);
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    for (int n = 0; n < 17; n++) fp_int[n] = '0;
    fp_int[1]  = 32'h3F800000; fp_int[2]  = 32'h40000000; fp_int[3]  = 32'h40400000;
    fp_int[4]  = 32'h40800000; fp_int[5]  = 32'h40A00000; fp_int[6]  = 32'h40C00000;
    fp_int[7]  = 32'h40E00000; fp_int[8]  = 32'h41000000; fp_int[9]  = 32'h41100000;
    fp_int[10] = 32'h41200000; fp_int[11] = 32'h41300000; fp_int[12] = 32'h41400000;
    fp_int[13] = 32'h41500000; fp_int[14] = 32'h41600000; fp_int[15] = 32'h41700000;
    fp_int[16] = 32'h41800000;
    kk = 0;
    first_strobe = 1'b0;
    last_exp = '0;

    fork
      monitor();
    join_none

    #1;
    check("reset_pool_out", POOL_OUT, 32'h0);
    check("reset_pool_valid", 32'(POOL_VALID), 32'd0);
    check("reset_done_all", 32'(DONE_ALL), 32'd0);

    basic_case("basic", 1'b0, 0);

    start(2, 2, 1);
    n_in = 4;
    vin[0] = 32'hC0400000; vin[1] = 32'hBFC00000; vin[2] = 32'hC0000000; vin[3] = 32'h80000000;
    push(32'h80000000);
    stream(1'b0, 0);
    wait_done("neg_mzero");

    start(2, 2, 1);
    vin[3] = 32'h00000000;
    push(32'h00000000);
    stream(1'b0, 0);
    wait_done("neg_pzero");

    start(3, 2, 1);
    n_in = 9;
    for (int n = 0; n < 9; n++) vin[n] = fp_int[n + 1];
    push(fp_int[5]); push(fp_int[6]); push(fp_int[8]); push(fp_int[9]);
    stream(1'b0, 0);
    wait_done("overlap_s1");

    start(3, 2, 2);
    push(fp_int[5]);
    stream(1'b0, 0);
    wait_done("overlap_s2");

    basic_case("gapped", 1'b1, 6);

    last_exp = '0;
    degen("k_gt_o", 4, 5, 1);
    degen("s_zero", 4, 2, 0);
    degen("o_too_big", 9, 2, 2);

    start(4, 2, 2);
    n_in = 16;
    for (int n = 0; n < 16; n++) vin[n] = fp_int[n + 1];
    push(32'h40C00000); push(32'h41000000); push(32'h41600000); push(32'h41800000);
    stream(1'b0, 0);
    begin
      int t;
      t = 0;
      while (exp_q.size() > 3 && t < 100) begin
        @(negedge CLK);
        t++;
      end
      check("mid_first_strobe_seen", 32'(exp_q.size()), 32'd3);
    end
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_pool_out", POOL_OUT, 32'h0);
    check("async_rst_pool_valid", 32'(POOL_VALID), 32'd0);
    check("async_rst_done_all", 32'(DONE_ALL), 32'd0);
    exp_q.delete();
    basic_case("restream", 1'b0, 0);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_max_pool.md
Name: fp_max_pool

Overview:
- Downstream stage of the FP32 2D convolution block.
- Captures the serialized O×O FP32 feature map that the conv block streams out on its FINAL_OUT/Done pair (row-major, index 0 first, one word per cycle while Done=1).
- Stores the map in a 64-entry buffer, then runs K×K max-pooling with stride S.
- Emits one pooled FP32 word per window, in row-major order.

Parameters:
- Width, 32, FP word width (IEEE-754 single: 1 sign, 8 exponent, 23 mantissa).
- Depth, 64, buffer entries; O1*O1 must be ≤ Depth.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- DIN  in  Width  feature-map word; connects to conv FINAL_OUT.
- DIN_VALID  in  1  DIN qualifier; connects to conv Done.
- O1  in  6  feature-map side length O.
- K1  in  6  pooling window side K.
- S1  in  6  pooling stride S.
- POOL_OUT  out  Width  pooled word; held between updates.
- POOL_VALID  out  1  one-cycle strobe marking POOL_OUT valid.
- DONE_ALL  out  1  high once all windows have been emitted.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all counters=0, POOL_OUT=0, POOL_VALID=0, DONE_ALL=0. Buffer contents are not reset.
- IDLE, one cycle:
  - Latch O=O1, K=K1, S=S1, N_tot=O1*O1.
  - If K==0, S==0, K>O or N_tot>Depth → DONE with zero outputs.
  - Otherwise → LOAD.
- LOAD:
  - On each DIN_VALID=1 cycle: buf[wr_cnt]<=DIN, wr_cnt++.
  - DIN_VALID=0 cycles hold wr_cnt; gaps are legal.
  - When wr_cnt==N_tot → POOL, with row0=col0=0, i=j=0.
  - Extra DIN_VALID beats arriving after the map is full are ignored in every later state.
- POOL, one element per cycle:
  - Address = (row0+i)*O + (col0+j).
  - First element of a window (i=j=0): acc<=buf[addr]. Otherwise acc<=fp_max(acc, buf[addr]).
  - j increments first; when j==K-1, j=0 and i++.
  - After element (K-1,K-1) → EMIT.
  - Each window takes exactly K*K cycles.
- EMIT, one cycle:
  - POOL_OUT<=acc, POOL_VALID=1.
  - Advance the origin: if col0+S+K ≤ O then col0+=S; else col0=0 and row0+=S.
  - If the new row0+K > O → DONE; else → POOL.
- Output count is Q×Q, with Q=floor((O-K)/S)+1. Positions that do not fit a full window are dropped; there are no partial windows and no padding.
- DONE: DONE_ALL=1, POOL_VALID=0, POOL_OUT holds the last value. The block stays in DONE until RST, matching the conv block's terminal state.
- Latency:
  - First POOL_VALID occurs K*K+1 cycles after the cycle in which the last input word was written.
  - Consecutive strobes are K*K+1 cycles apart.
- fp_max(a,b), combinational:
  - Total order by sign-magnitude: positive > negative; among positives, larger {exp,mant} wins; among negatives, smaller {exp,mant} wins.
  - +0 > -0. Equal inputs return a.
  - NaN/Inf receive no special handling; they are ordered by bit pattern under the same rule.
- Width rules: address arithmetic is 12-bit internally, with no truncation for O ≤ 8.
- POOL_VALID is never high in IDLE, LOAD or DONE.

Decomposition:
- Shared package holds:
  - FP field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_MSB=22.
  - State encoding: IDLE, LOAD, POOL, EMIT, DONE as 3-bit localparams.
- One sub-module: fp32_max_cmp, the combinational sign-magnitude comparator/selector. It is reusable for a later ReLU stage (max with +0).

Test Plan:
- Basic pooling, O=4, K=2, S=2; stream 1.0..16.0 (0x3F800000..0x41800000) → 4 strobes: 6.0, 8.0, 14.0, 16.0 (0x40C00000, 0x41000000, 0x41600000, 0x41800000); then DONE_ALL=1; strobes K*K+1=5 cycles apart.
- Negative values, O=2, K=2, S=1; inputs -3.0, -1.5, -2.0, -0.0 → single strobe 0x80000000 (-0.0). Repeat with +0.0 replacing -0.0 → 0x00000000.
- Overlap, O=3, K=2, S=1; inputs 1..9 → strobes 5, 6, 8, 9 (FP32 encodings). With S=2 → single strobe 5.0 (Q=1).
- Gapped input: O=4, K=2, S=2; DIN_VALID toggles 1/0 every cycle → same outputs as the basic case. Six extra valid beats after the 16th word → no change to output.
- Degenerate parameters: K=5 with O=4, or S=0 → DONE_ALL=1 at cycle 2 after reset release, no POOL_VALID. O=9 (81>64) → same response.
- Reset mid-operation: assert RST during POOL after one strobe → POOL_OUT=0, POOL_VALID=0 and DONE_ALL=0 immediately (async). After release, a full restream gives the correct complete output set.
